key_set_ctrl: RTL



---
 rtl/key_set_ctrl_pkg.sv | 21 ++
 rtl/key_set_ctrl_ms_timer.sv | 33 +++
 rtl/key_set_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/key_set_ctrl_pkg.sv
// Shared constants for the calendar time-set key controller: field indices,
// FSM state encoding and counter widths.
package key_set_ctrl_pkg;

    localparam int FIELD_W  = 3;
    localparam int MS_CNT_W = 16;

    localparam logic [FIELD_W-1:0] FLD_YEAR  = 3'd0;
    localparam logic [FIELD_W-1:0] FLD_MONTH = 3'd1;
    localparam logic [FIELD_W-1:0] FLD_DAY   = 3'd2;
    localparam logic [FIELD_W-1:0] FLD_HOUR  = 3'd3;
    localparam logic [FIELD_W-1:0] FLD_MIN   = 3'd4;
    localparam logic [FIELD_W-1:0] FLD_SEC   = 3'd5;

    // Two-bit encoding leaves spare codes; any of them falls back to run mode.
    typedef enum logic [1:0] {
        ST_RUN = 2'b00,
        ST_SET = 2'b01
    } state_t;

endpackage

// File: rtl/key_set_ctrl_ms_timer.sv
// Millisecond counter advanced by the shared 1 ms strobe; wraps to zero and
// flags done on the tick that brings it to the limit.
module key_set_ctrl_ms_timer
    import key_set_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic                tick,
    input  logic [MS_CNT_W-1:0] limit,
    output logic                done
);

    logic [MS_CNT_W-1:0] count;
    logic                hit;

    assign hit = (count == (limit - MS_CNT_W'(1)));

    // A clear in the same cycle as the final tick suppresses done.
    assign done = en & tick & ~clr & hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && tick) begin
            count <= hit ? '0 : count + MS_CNT_W'(1);
        end
    end

endmodule

// File: rtl/key_set_ctrl.sv
// Turns debounced MODE/UP/DOWN key pulses into calendar set-mode control:
// field selection, inc/dec strobes, inactivity auto-exit and field blink.
module key_set_ctrl
    import key_set_ctrl_pkg::*;
#(
    parameter int unsigned NUM_FIELDS = 6,
    parameter int unsigned TIMEOUT_MS = 10000,
    parameter int unsigned BLINK_MS   = 500
) (
    input  logic               SYS_CLK,
    input  logic               SYS_RST_N,
    input  logic               MS_F,
    input  logic               KEY_MODE,
    input  logic               KEY_UP,
    input  logic               KEY_DN,
    output logic               SET_MODE,
    output logic [FIELD_W-1:0] FIELD_SEL,
    output logic               INC_P,
    output logic               DEC_P,
    output logic               BLINK,
    output logic               EXIT_P
);

    localparam logic [FIELD_W-1:0]  LAST_FIELD  = FIELD_W'(NUM_FIELDS - 1);
    localparam logic [MS_CNT_W-1:0] TIMEOUT_LIM = MS_CNT_W'(TIMEOUT_MS);
    localparam logic [MS_CNT_W-1:0] BLINK_LIM   = MS_CNT_W'(BLINK_MS);

    state_t state;
    state_t next_state;

    logic               in_set;
    logic               any_key;
    logic               up_only;
    logic               dn_only;
    logic               field_last;
    logic               strobe_busy;
    logic               idle_clr;
    logic               idle_done;
    logic               blink_clr;
    logic               blink_done;

    logic               set_n;
    logic [FIELD_W-1:0] field_n;
    logic               inc_n;
    logic               dec_n;
    logic               blink_n;
    logic               exit_n;

    assign in_set      = (state == ST_SET);
    assign any_key     = KEY_MODE | KEY_UP | KEY_DN;
    assign up_only     = KEY_UP & ~KEY_DN & ~KEY_MODE;
    assign dn_only     = KEY_DN & ~KEY_UP & ~KEY_MODE;
    assign field_last  = (FIELD_SEL >= LAST_FIELD);
    assign strobe_busy = INC_P | DEC_P;

    // Counters sit at zero outside set mode; any key restarts the idle window,
    // while only keys that refresh the display restart the blink phase.
    assign idle_clr  = ~in_set | any_key;
    assign blink_clr = ~in_set | KEY_MODE | (KEY_UP ^ KEY_DN) | idle_done;

    key_set_ctrl_ms_timer u_idle_timer (
        .clk   (SYS_CLK),
        .rst_n (SYS_RST_N),
        .clr   (idle_clr),
        .en    (in_set),
        .tick  (MS_F),
        .limit (TIMEOUT_LIM),
        .done  (idle_done)
    );

    key_set_ctrl_ms_timer u_blink_timer (
        .clk   (SYS_CLK),
        .rst_n (SYS_RST_N),
        .clr   (blink_clr),
        .en    (in_set),
        .tick  (MS_F),
        .limit (BLINK_LIM),
        .done  (blink_done)
    );

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state     <= ST_RUN;
            SET_MODE  <= 1'b0;
            FIELD_SEL <= FLD_YEAR;
            INC_P     <= 1'b0;
            DEC_P     <= 1'b0;
            BLINK     <= 1'b0;
            EXIT_P    <= 1'b0;
        end else begin
            state     <= next_state;
            SET_MODE  <= set_n;
            FIELD_SEL <= field_n;
            INC_P     <= inc_n;
            DEC_P     <= dec_n;
            BLINK     <= blink_n;
            EXIT_P    <= exit_n;
        end
    end

    always_comb begin
        next_state = ST_RUN;
        case (state)
            ST_RUN: begin
                next_state = KEY_MODE ? ST_SET : ST_RUN;
            end
            ST_SET: begin
                next_state = ST_SET;
                if (KEY_MODE && field_last) begin
                    next_state = ST_RUN;
                end else if (idle_done) begin
                    next_state = ST_RUN;
                end
            end
            default: begin
                next_state = ST_RUN;
            end
        endcase
    end

    // Strobes are one-cycle pulses with no handshake: the calendar counters
    // must act on every cycle INC_P/DEC_P/EXIT_P is high, and never see two
    // consecutive inc/dec cycles.
    always_comb begin
        set_n   = (next_state == ST_SET);
        field_n = FIELD_SEL;
        inc_n   = 1'b0;
        dec_n   = 1'b0;
        blink_n = BLINK;
        exit_n  = 1'b0;
        case (state)
            ST_RUN: begin
                field_n = FLD_YEAR;
                blink_n = KEY_MODE;
            end
            ST_SET: begin
                if (KEY_MODE) begin
                    if (field_last) begin
                        field_n = FLD_YEAR;
                        blink_n = 1'b0;
                        exit_n  = 1'b1;
                    end else begin
                        field_n = FIELD_SEL + FIELD_W'(1);
                        blink_n = 1'b1;
                    end
                end else if (up_only) begin
                    inc_n   = ~strobe_busy;
                    blink_n = 1'b1;
                end else if (dn_only) begin
                    dec_n   = ~strobe_busy;
                    blink_n = 1'b1;
                end else if (idle_done) begin
                    field_n = FLD_YEAR;
                    blink_n = 1'b0;
                    exit_n  = 1'b1;
                end else if (blink_done) begin
                    blink_n = ~BLINK;
                end
            end
            default: begin
                field_n = FLD_YEAR;
                blink_n = 1'b0;
            end
        endcase
    end

endmodule
